// File: rtl/crc_stream_master.sv
// rtl/crc_stream_master.sv - bus initiator that programs the CRC peripheral and streams a job through it
// Preamble writes, per-word data writes, then a result read; all bus outputs are registered.
module crc_stream_master #(
  parameter logic [31:0] BASE_ADDR = 32'h4003_2000,
  parameter int unsigned WAS_BIT   = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_poly,
  input  logic [31:0] cfg_ctrl,
  input  logic [31:0] cfg_seed,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        bus_rw,
  output logic        bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic [31:0] crc_out,
  output logic        crc_valid,
  output logic [15:0] word_count
);

  typedef enum logic [3:0] {
    IDLE, W_POLY, W_CSEED, W_SEED, W_CRUN, DATA, FLUSH, READ, DONE
  } state_t;

  localparam logic [31:0] ADDR_DATA = BASE_ADDR;
  localparam logic [31:0] ADDR_POLY = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_CTRL = BASE_ADDR + 32'h8;
  localparam logic [31:0] WAS_MASK  = 32'h1 << WAS_BIT;

  state_t      state, state_nxt;
  logic [31:0] ctrl_q, seed_q;
  logic        rw_nxt, sel_nxt;
  logic [31:0] addr_nxt, wdata_nxt;
  logic        handshake, accept_start;

  assign in_ready     = (state == W_CRUN) || (state == DATA);
  assign handshake    = in_valid && in_ready && !abort;
  assign accept_start = (state == IDLE) && start && !abort;
  assign busy         = (state != IDLE);
  assign crc_valid    = (state == DONE);

  // Bus registers are loaded with the access belonging to the state being entered.
  always_comb begin
    state_nxt = state;
    rw_nxt    = 1'b0;
    sel_nxt   = 1'b0;
    addr_nxt  = BASE_ADDR;
    wdata_nxt = '0;
    case (state)
      IDLE: begin
        if (accept_start) begin
          state_nxt = W_POLY;
          rw_nxt    = 1'b1;
          sel_nxt   = 1'b1;
          addr_nxt  = ADDR_POLY;
          wdata_nxt = cfg_poly;
        end
      end
      W_POLY: begin
        state_nxt = W_CSEED;
        rw_nxt    = 1'b1;
        sel_nxt   = 1'b1;
        addr_nxt  = ADDR_CTRL;
        wdata_nxt = ctrl_q | WAS_MASK;
      end
      W_CSEED: begin
        state_nxt = W_SEED;
        rw_nxt    = 1'b1;
        sel_nxt   = 1'b1;
        addr_nxt  = ADDR_DATA;
        wdata_nxt = seed_q;
      end
      W_SEED: begin
        state_nxt = W_CRUN;
        rw_nxt    = 1'b1;
        sel_nxt   = 1'b1;
        addr_nxt  = ADDR_CTRL;
        wdata_nxt = ctrl_q & ~WAS_MASK;
      end
      W_CRUN, DATA: begin
        state_nxt = DATA;
        if (handshake) begin
          rw_nxt    = 1'b1;
          sel_nxt   = 1'b1;
          addr_nxt  = ADDR_DATA;
          wdata_nxt = in_data;
          if (in_last) state_nxt = FLUSH;
        end
      end
      FLUSH:   state_nxt = READ;  // read of the data register shares the idle encoding
      READ:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      rw_nxt    = 1'b0;
      sel_nxt   = 1'b0;
      addr_nxt  = BASE_ADDR;
      wdata_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bus_rw     <= 1'b0;
      bus_sel    <= 1'b0;
      bus_addr   <= BASE_ADDR;
      bus_wdata  <= '0;
      ctrl_q     <= '0;
      seed_q     <= '0;
      crc_out    <= '0;
      word_count <= '0;
    end else begin
      state     <= state_nxt;
      bus_rw    <= rw_nxt;
      bus_sel   <= sel_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
      if (accept_start) begin
        ctrl_q     <= cfg_ctrl;
        seed_q     <= cfg_seed;
        word_count <= '0;
      end else if (handshake && (word_count != 16'hFFFF)) begin
        word_count <= word_count + 16'd1;
      end
      if ((state == READ) && !abort) crc_out <= bus_rdata;
    end
  end

endmodule
